rom_fetch_unit: RTL

Parametrised instruction-fetch front end that streams words out of the synchronous on-chip instruction ROM. It holds the program counter, issues word addresses to the ROM (one-cycle read latency), and buffers returned data in a small FIFO so the core can apply backpressure without losing words. It also supports PC redirect (branch/jump) with flush, and flags misaligned redirect targets. It sits between the `rom` instance and the RISC-V decode stage.

---
 rtl/rom_fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rom_fetch_unit.sv
// Instruction-fetch front end: walks the PC through a synchronous ROM (one-cycle
// latency) and buffers returned words in a small credit-controlled FIFO.
module rom_fetch_unit #(
    parameter int                       ADDRESS_WIDTH = 8,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       FIFO_DEPTH    = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = {ADDRESS_WIDTH{1'b0}}
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic [ADDRESS_WIDTH-3:0] rom_address,
    input  logic [DATA_WIDTH-1:0]    rom_q,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic                     out_error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } mode_e;

    mode_e                     mode_r;
    mode_e                     mode_next_s;
    logic [ADDRESS_WIDTH-1:0]  fetch_pc_r;
    logic                      inflight_r;
    logic [ADDRESS_WIDTH-1:0]  inflight_pc_r;
    logic [ADDRESS_WIDTH-1:0]  pc_mem_r    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     instr_mem_r [FIFO_DEPTH];
    logic                      err_mem_r   [FIFO_DEPTH];
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [CNT_W-1:0]          count_r;

    logic                      pop_s;
    logic                      push_s;
    logic                      issue_s;
    logic                      misaligned_s;
    logic [CNT_W:0]            used_s;
    logic [CNT_W:0]            limit_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // A slot is reserved for every word in flight, so the FIFO can never overflow.
    assign pop_s        = (count_r != {CNT_W{1'b0}}) && out_ready;
    assign push_s       = inflight_r && !redirect_valid;
    assign misaligned_s = (redirect_pc[1:0] != 2'b00);
    assign used_s       = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    assign limit_s      = (CNT_W + 1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop_s};
    assign issue_s      = (mode_r == MODE_RUN) && !redirect_valid && (used_s < limit_s);

    assign rom_address = fetch_pc_r[ADDRESS_WIDTH-1:2];
    assign out_valid   = (count_r != {CNT_W{1'b0}});
    assign out_pc      = out_valid ? pc_mem_r[rd_ptr_r]    : {ADDRESS_WIDTH{1'b0}};
    assign out_instr   = out_valid ? instr_mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign out_error   = out_valid ? err_mem_r[rd_ptr_r]   : 1'b0;

    // Mode register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mode_r <= MODE_RUN;
        end else begin
            mode_r <= mode_next_s;
        end
    end

    // Mode next-state: only a redirect moves between RUN and HALT.
    always_comb begin
        mode_next_s = mode_r;
        case (mode_r)
            MODE_RUN, MODE_HALT: begin
                if (redirect_valid) begin
                    mode_next_s = misaligned_s ? MODE_HALT : MODE_RUN;
                end else begin
                    mode_next_s = mode_r;
                end
            end
            default: mode_next_s = MODE_RUN;
        endcase
    end

    // PC, in-flight tracking and FIFO storage; redirect overrides issue, push and pop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDRESS_WIDTH{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            inflight_r <= 1'b0;
            rd_ptr_r   <= {PTR_W{1'b0}};
            if (misaligned_s) begin
                // The error marker is the only entry; fetch stays parked at the aligned word.
                fetch_pc_r        <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
                pc_mem_r[0]       <= redirect_pc;
                instr_mem_r[0]    <= {DATA_WIDTH{1'b0}};
                err_mem_r[0]      <= 1'b1;
                wr_ptr_r          <= ptr_inc({PTR_W{1'b0}});
                count_r           <= CNT_W'(1);
            end else begin
                fetch_pc_r <= redirect_pc;
                wr_ptr_r   <= {PTR_W{1'b0}};
                count_r    <= {CNT_W{1'b0}};
            end
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= fetch_pc_r;
                fetch_pc_r    <= fetch_pc_r + ADDRESS_WIDTH'(4);
            end
            if (push_s) begin
                pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
                instr_mem_r[wr_ptr_r] <= rom_q;
                err_mem_r[wr_ptr_r]   <= 1'b0;
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
